// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 RX packet parser: header ECC check/correct, FS/FE framing, pixel payload forwarding.
// Define CSI2_RX_CRC_CHECK_EN to build the payload CRC-16 checker; otherwise CRC bytes are discarded.
module csi2_rx_packet_parser #(
  parameter logic [5:0] PIX_DT = 6'h2B,
  parameter logic [1:0] VC_SEL = 2'd0
) (
  input  logic        byte_clk,
  input  logic        byte_rst_n,
  input  logic        rx_sync_i,
  input  logic        rx_valid_i,
  input  logic [15:0] rx_data_i,
  input  logic        rx_hs_active_i,
  output logic        fv_o,
  output logic        lv_o,
  output logic [15:0] pix_data_o,
  output logic [1:0]  pix_en_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] frame_num_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        pkt_done_o,
  output logic        ecc_corr_o,
  output logic        ecc_err_o,
  output logic        crc_err_o,
  output logic        trunc_err_o
);

  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CRC, WAIT_EOT} state_t;

  // Syndrome produced by a flip of each header data bit D0..D23.
  localparam logic [5:0] ECC_CODE [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) p = p ^ ECC_CODE[i];
    end
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] hdr0_q, hdr0_d;
  logic [15:0] rem_q, rem_d;
  logic        fwd_q, fwd_d;

  logic        fv_d, lv_d, sof_d, eof_d, done_d, corr_d, eerr_d, trunc_d;
  logic [15:0] pix_data_d, frame_d, wc_d;
  logic [1:0]  pix_en_d;
  logic [5:0]  dt_d;

  logic [23:0] hdr, fixed;
  logic [5:0]  syn;
  logic        hit, single, restart, in_pkt;
  logic [7:0]  di;
  logic [15:0] wcv;

`ifdef CSI2_RX_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d, crc_rx;
  logic [7:0]  crc_lo_q, crc_lo_d;
  logic        crc_err_d;

  // Byte-at-a-time form of the reflected 0x8408 CRC.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = d ^ c[7:0];
    x = x ^ {x[3:0], 4'h0};
    return {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
  endfunction
`endif

  // Header decode: word0 holds {WC_L, DI}, current word holds {ECC, WC_H}.
  always_comb begin
    hdr   = {rx_data_i[7:0], hdr0_q};
    syn   = ecc_calc(hdr) ^ rx_data_i[13:8];
    fixed = hdr;
    hit   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (syn == ECC_CODE[i]) begin
        fixed[i] = ~hdr[i];
        hit      = 1'b1;
      end
    end
    single = hit || $onehot(syn);
    di     = fixed[7:0];
    wcv    = fixed[23:8];
  end

  assign restart = rx_valid_i && rx_sync_i;
  assign in_pkt  = (state_q == HDR1) || (state_q == PAYLOAD) || (state_q == CRC);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    hdr0_d     = hdr0_q;
    rem_d      = rem_q;
    fwd_d      = fwd_q;
    fv_d       = fv_o;
    frame_d    = frame_num_o;
    dt_d       = dt_o;
    wc_d       = wc_o;
    pix_data_d = pix_data_o;
    pix_en_d   = 2'b00;
    lv_d       = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    done_d     = 1'b0;
    corr_d     = 1'b0;
    eerr_d     = 1'b0;
    trunc_d    = 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
    crc_d      = crc_q;
    crc_lo_d   = crc_lo_q;
    crc_err_d  = 1'b0;
    crc_rx     = wc_o[0] ? {rx_data_i[7:0], crc_lo_q} : rx_data_i;
`endif

    if (in_pkt && (!rx_hs_active_i || restart)) begin
      // EoT or a fresh SoT in mid-packet: drop it; a fresh SoT word is a new header.
      trunc_d = 1'b1;
      state_d = restart ? HDR1 : IDLE;
      if (restart) hdr0_d = rx_data_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (restart) begin
            hdr0_d  = rx_data_i;
            state_d = HDR1;
          end
        end

        HDR1: begin
          if (rx_valid_i) begin
            if ((syn != 6'd0) && !single) begin
              eerr_d  = 1'b1;
              state_d = WAIT_EOT;
            end else begin
              corr_d = (syn != 6'd0);
              if (di[5:0] <= 6'h0F) begin
                if (di[7:6] == VC_SEL) begin
                  if (di[5:0] == 6'h00) begin
                    sof_d   = 1'b1;
                    fv_d    = 1'b1;
                    frame_d = wcv;
                  end else if (di[5:0] == 6'h01) begin
                    eof_d = 1'b1;
                    fv_d  = 1'b0;
                  end
                end
                state_d = WAIT_EOT;
              end else begin
                dt_d    = di[5:0];
                wc_d    = wcv;
                rem_d   = wcv;
                fwd_d   = (di[5:0] == PIX_DT) && (di[7:6] == VC_SEL);
                state_d = (wcv == 16'd0) ? CRC : PAYLOAD;
`ifdef CSI2_RX_CRC_CHECK_EN
                crc_d   = 16'hFFFF;
`endif
              end
            end
          end
        end

        PAYLOAD: begin
          if (!rx_valid_i) begin
            lv_d = lv_o;
          end else begin
            if (fwd_q) begin
              lv_d       = 1'b1;
              pix_data_d = rx_data_i;
              pix_en_d   = (rem_q == 16'd1) ? 2'b01 : 2'b11;
            end
            if (rem_q == 16'd1) begin
              // Odd count: lane1 of this word already carries the CRC low byte.
              rem_d   = 16'd0;
              state_d = CRC;
`ifdef CSI2_RX_CRC_CHECK_EN
              crc_d    = crc_byte(crc_q, rx_data_i[7:0]);
              crc_lo_d = rx_data_i[15:8];
`endif
            end else begin
              rem_d = rem_q - 16'd2;
              if (rem_q == 16'd2) state_d = CRC;
`ifdef CSI2_RX_CRC_CHECK_EN
              crc_d = crc_byte(crc_byte(crc_q, rx_data_i[7:0]), rx_data_i[15:8]);
`endif
            end
          end
        end

        CRC: begin
          if (rx_valid_i) begin
            done_d  = 1'b1;
            state_d = WAIT_EOT;
`ifdef CSI2_RX_CRC_CHECK_EN
            crc_err_d = (crc_rx != crc_q);
`endif
          end
        end

        WAIT_EOT: begin
          if (!rx_hs_active_i) begin
            state_d = IDLE;
          end else if (restart) begin
            hdr0_d  = rx_data_i;
            state_d = HDR1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge byte_clk or negedge byte_rst_n) begin
    if (!byte_rst_n) begin
      state_q     <= IDLE;
      hdr0_q      <= '0;
      rem_q       <= '0;
      fwd_q       <= 1'b0;
      fv_o        <= 1'b0;
      lv_o        <= 1'b0;
      pix_data_o  <= '0;
      pix_en_o    <= 2'b00;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      frame_num_o <= '0;
      dt_o        <= '0;
      wc_o        <= '0;
      pkt_done_o  <= 1'b0;
      ecc_corr_o  <= 1'b0;
      ecc_err_o   <= 1'b0;
      trunc_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr0_q      <= hdr0_d;
      rem_q       <= rem_d;
      fwd_q       <= fwd_d;
      fv_o        <= fv_d;
      lv_o        <= lv_d;
      pix_data_o  <= pix_data_d;
      pix_en_o    <= pix_en_d;
      sof_o       <= sof_d;
      eof_o       <= eof_d;
      frame_num_o <= frame_d;
      dt_o        <= dt_d;
      wc_o        <= wc_d;
      pkt_done_o  <= done_d;
      ecc_corr_o  <= corr_d;
      ecc_err_o   <= eerr_d;
      trunc_err_o <= trunc_d;
    end
  end

`ifdef CSI2_RX_CRC_CHECK_EN
  always_ff @(posedge byte_clk or negedge byte_rst_n) begin
    if (!byte_rst_n) begin
      crc_q     <= 16'hFFFF;
      crc_lo_q  <= '0;
      crc_err_o <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_lo_q  <= crc_lo_d;
      crc_err_o <= crc_err_d;
    end
  end
`else
  assign crc_err_o = 1'b0;
`endif

endmodule
